// File: rtl/packet_arbiter_pkg.sv
// packet_arbiter shared types and helpers.
// Imported by the arbiter top and its round-robin picker.
package packet_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  function automatic int res_width(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/packet_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Purely combinational; any=0 when no request is set.
module rr_picker
  import packet_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[(int'(ptr) + i) % N]) begin
        any = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/packet_arbiter.sv
// Packet-granular round-robin arbiter in front of packet_translator.
// Locks grant sop..eop, flushes stray beats, aborts stalled packets.
module packet_arbiter
  import packet_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int RES_WIDTH      = res_width(DATA_WIDTH),
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                            iclk,
  input  logic                            irst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_sop,
  input  logic [NUM_REQ-1:0]              req_eop,
  input  logic [NUM_REQ-1:0]              req_bad,
  input  logic [NUM_REQ*RES_WIDTH-1:0]    req_residual,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            ipause,
  output logic                            ovalid,
  output logic                            osop,
  output logic                            oeop,
  output logic                            obad,
  output logic [RES_WIDTH-1:0]            oresidual,
  output logic [DATA_WIDTH-1:0]           odata,
  output logic [$clog2(NUM_REQ)-1:0]      ogrant_id,
  output logic                            obusy,
  output logic                            otimeout_irq,
  output logic [NUM_REQ*CNT_WIDTH-1:0]    opkt_cnt
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        pick_idx;
  logic [IW-1:0]        nxt_ptr;
  logic                 pick_any;
  logic [NUM_REQ-1:0]   elig;
  logic                 first;
  logic                 err;
  logic                 err_nx;
  logic                 acc;
  logic [WW-1:0]        wd;
  logic                 g_valid;
  logic                 g_sop;
  logic                 g_eop;
  logic                 g_bad;
  logic [RES_WIDTH-1:0] g_res;
  logic [DATA_WIDTH-1:0] g_data;
  logic [CNT_WIDTH-1:0] cnt_inc;

  assign elig = req_valid & req_sop;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req (elig),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign g_valid = req_valid[ogrant_id];
  assign g_sop   = req_sop[ogrant_id];
  assign g_eop   = req_eop[ogrant_id];
  assign g_bad   = req_bad[ogrant_id];
  assign g_res   = req_residual[ogrant_id*RES_WIDTH +: RES_WIDTH];
  assign g_data  = req_data[ogrant_id*DATA_WIDTH +: DATA_WIDTH];
  assign cnt_inc = opkt_cnt[ogrant_id*CNT_WIDTH +: CNT_WIDTH] + 1'b1;

  assign acc     = (state == ST_XFER) && !ipause && g_valid;
  // A sop after the first beat poisons the rest of the packet
  assign err_nx  = err | (g_sop & ~first);
  assign nxt_ptr = (ogrant_id == IW'(NUM_REQ - 1)) ? '0 : ogrant_id + 1'b1;

  always_comb begin
    req_ready = '0;
    unique case (state)
      ST_IDLE: req_ready = req_valid & ~req_sop;
      ST_XFER: req_ready[ogrant_id] = !ipause;
      default: req_ready = '0;
    endcase
    if (!irst_n) req_ready = '0;
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      first        <= 1'b0;
      err          <= 1'b0;
      wd           <= '0;
      ovalid       <= 1'b0;
      osop         <= 1'b0;
      oeop         <= 1'b0;
      obad         <= 1'b0;
      oresidual    <= '0;
      odata        <= '0;
      ogrant_id    <= '0;
      obusy        <= 1'b0;
      otimeout_irq <= 1'b0;
      opkt_cnt     <= '0;
    end else begin
      ovalid       <= 1'b0;
      osop         <= 1'b0;
      oeop         <= 1'b0;
      obad         <= 1'b0;
      oresidual    <= '0;
      odata        <= '0;
      otimeout_irq <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state     <= ST_XFER;
            ogrant_id <= pick_idx;
            obusy     <= 1'b1;
            first     <= 1'b1;
            err       <= 1'b0;
            wd        <= '0;
          end
        end
        ST_XFER: begin
          if (acc) begin
            ovalid    <= 1'b1;
            osop      <= first;
            oeop      <= g_eop;
            odata     <= g_data;
            oresidual <= g_eop ? g_res : '0;
            obad      <= g_eop & (g_bad | err_nx);
            first     <= 1'b0;
            err       <= err_nx;
            wd        <= '0;
            if (g_eop) begin
              state  <= ST_IDLE;
              obusy  <= 1'b0;
              rr_ptr <= nxt_ptr;
              opkt_cnt[ogrant_id*CNT_WIDTH +: CNT_WIDTH] <= cnt_inc;
            end
          end else if (!ipause) begin
            if (wd == WD_LAST) state <= ST_ABORT;
            else wd <= wd + 1'b1;
          end
        end
        ST_ABORT: begin
          if (!ipause) begin
            ovalid       <= 1'b1;
            oeop         <= 1'b1;
            obad         <= 1'b1;
            otimeout_irq <= 1'b1;
            state        <= ST_IDLE;
            obusy        <= 1'b0;
            rr_ptr       <= nxt_ptr;
            opkt_cnt[ogrant_id*CNT_WIDTH +: CNT_WIDTH] <= cnt_inc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
